// File: rtl/text_writer.sv
// Text-mode writer: turns a stream of ASCII bytes into screen-RAM cell writes.
// It tracks a text cursor, handles CR/LF/BS/FF, clears a row when the cursor
// moves onto it, and clears the whole screen after reset or on FF.
module text_writer #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 40
) (
    input  logic        clock50,
    input  logic        reset_n,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [6:0]  wr_data,
    output logic [6:0]  cursor_col,
    output logic [5:0]  cursor_row
);

    localparam int unsigned AW        = 12;
    localparam logic [6:0]  COL_LAST  = 7'(COLS - 1);
    localparam logic [5:0]  ROW_LAST  = 6'(ROWS - 1);
    localparam logic [AW-1:0] CELL_LAST = AW'(COLS * ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_CLEAR_ROW,
        S_CLEAR_ALL
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      col_q, col_d;
    logic [5:0]      row_q, row_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [6:0]      data_q, data_d;
    logic            adv_q, adv_d;      // WRITE advances the cursor (printable) or not (BS)

    logic [5:0]      next_row;
    logic [AW-1:0]   row_base;
    logic [AW-1:0]   next_row_base;
    logic [AW-1:0]   cur_addr;
    logic            printable;

    assign char_ready = (state_q == S_IDLE);
    assign wr_en      = wr_en_q;
    assign wr_addr    = addr_q;
    assign wr_data    = data_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

    // State and output registers, synchronous active-low reset into CLEAR_ALL.
    always_ff @(posedge clock50) begin
        if (!reset_n) begin
            state_q <= S_CLEAR_ALL;
            col_q   <= '0;
            row_q   <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            adv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            adv_q   <= adv_d;
        end
    end

    // Next-state logic: byte decode in IDLE, cursor update and clear sequencing.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        wr_en_d = wr_en_q;
        addr_d  = addr_q;
        data_d  = data_q;
        adv_d   = adv_q;

        next_row      = (row_q == ROW_LAST) ? '0 : row_q + 6'd1;
        row_base      = AW'(row_q) * AW'(COLS);
        next_row_base = AW'(next_row) * AW'(COLS);
        cur_addr      = row_base + AW'(col_q);
        printable     = (char_in >= 8'h20) && (char_in <= 8'h7E);

        case (state_q)
            S_IDLE: begin
                if (char_valid) begin
                    if (printable) begin
                        state_d = S_WRITE;
                        wr_en_d = 1'b1;
                        addr_d  = cur_addr;
                        data_d  = 7'(char_in - 8'h20);
                        adv_d   = 1'b1;
                    end else begin
                        case (char_in)
                            8'h0A: begin
                                col_d   = '0;
                                row_d   = next_row;
                                state_d = S_CLEAR_ROW;
                                wr_en_d = 1'b1;
                                addr_d  = next_row_base;
                                data_d  = '0;
                            end
                            8'h0D: begin
                                col_d = '0;
                            end
                            8'h08: begin
                                if (col_q != '0) begin
                                    col_d   = col_q - 7'd1;
                                    state_d = S_WRITE;
                                    wr_en_d = 1'b1;
                                    addr_d  = cur_addr - AW'(1);
                                    data_d  = '0;
                                    adv_d   = 1'b0;
                                end
                            end
                            8'h0C: begin
                                col_d   = '0;
                                row_d   = '0;
                                state_d = S_CLEAR_ALL;
                                wr_en_d = 1'b1;
                                addr_d  = '0;
                                data_d  = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            S_WRITE: begin
                wr_en_d = 1'b0;
                state_d = S_IDLE;
                if (adv_q) begin
                    if (col_q == COL_LAST) begin
                        // Wrap goes straight into the row clear without a gap cycle.
                        col_d   = '0;
                        row_d   = next_row;
                        state_d = S_CLEAR_ROW;
                        wr_en_d = 1'b1;
                        addr_d  = next_row_base;
                        data_d  = '0;
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                end
            end

            S_CLEAR_ROW: begin
                if (addr_q == row_base + AW'(COL_LAST)) begin
                    wr_en_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end

            S_CLEAR_ALL: begin
                if (!wr_en_q) begin
                    // Only reached right after reset: start the sweep at cell 0.
                    wr_en_d = 1'b1;
                    addr_d  = '0;
                    data_d  = '0;
                end else if (addr_q == CELL_LAST) begin
                    wr_en_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: table of single-byte vectors plus
// hand-written sequences for row wrap, LF wrap, BS, FF and mid-clear reset.
module tb_text_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [6:0]  wr_data;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;

    int n_total = 0;
    int n_bad   = 0;

    text_writer #(.COLS(80), .ROWS(40)) dut (
        .clock50   (clk),
        .reset_n   (reset_n),
        .char_in   (char_in),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ch;
        bit         wr;
        int         addr;
        int         data;
        int         col;
        int         row;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Wait (bounded) for char_ready, then transfer one byte; returns #1 after the accept edge.
    task automatic send(input logic [7:0] b);
        int w = 0;
        while (!char_ready && w < 4000) begin
            tick();
            w++;
        end
        if (!char_ready) check("send ready timeout", 0, 1);
        char_in    = b;
        char_valid = 1'b1;
        tick();
        char_valid = 1'b0;
    endtask

    // Count a run of consecutive zero writes starting at 'start'.
    task automatic count_clear(input int start, input int expn, input string name);
        int n = 0, badw = 0, rdy = 0, w = 0;
        while (!wr_en && w < 5) begin
            tick();
            w++;
        end
        while (wr_en && n < expn + 10) begin
            if (int'(wr_addr) != start + n || wr_data != 7'd0) badw++;
            if (char_ready) rdy++;
            n++;
            tick();
        end
        check({name, " count"}, n, expn);
        check({name, " addr/data"}, badw, 0);
        check({name, " ready during clear"}, rdy, 0);
        check({name, " ready after"}, int'(char_ready), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int badw;
        vecs[0]  = '{8'h41, 1, 0, 8'h21, 1, 0};
        vecs[1]  = '{8'h42, 1, 1, 8'h22, 2, 0};
        vecs[2]  = '{8'h20, 1, 2, 8'h00, 3, 0};
        vecs[3]  = '{8'h7E, 1, 3, 8'h5E, 4, 0};
        vecs[4]  = '{8'h7F, 0, 0, 0,     4, 0};
        vecs[5]  = '{8'h0D, 0, 0, 0,     0, 0};
        vecs[6]  = '{8'h08, 0, 0, 0,     0, 0};
        vecs[7]  = '{8'h7A, 1, 0, 8'h5A, 1, 0};
        vecs[8]  = '{8'h08, 1, 0, 8'h00, 0, 0};
        vecs[9]  = '{8'h1F, 0, 0, 0,     0, 0};
        vecs[10] = '{8'h80, 0, 0, 0,     0, 0};

        reset_n    = 1'b0;
        char_in    = 8'h00;
        char_valid = 1'b0;
        repeat (3) tick();
        check("reset wr_en", int'(wr_en), 0);
        check("reset wr_addr", int'(wr_addr), 0);
        check("reset wr_data", int'(wr_data), 0);
        check("reset ready", int'(char_ready), 0);
        check("reset col", int'(cursor_col), 0);
        check("reset row", int'(cursor_row), 0);
        reset_n = 1'b1;
        count_clear(0, 3200, "power-up clear");

        // Table of single bytes from (0,0).
        for (int i = 0; i < 11; i++) begin
            send(vecs[i].ch);
            if (vecs[i].wr) begin
                check($sformatf("vec%0d wr_en", i), int'(wr_en), 1);
                check($sformatf("vec%0d addr", i), int'(wr_addr), vecs[i].addr);
                check($sformatf("vec%0d data", i), int'(wr_data), vecs[i].data);
                check($sformatf("vec%0d busy", i), int'(char_ready), 0);
                tick();
            end
            check($sformatf("vec%0d no write", i), int'(wr_en), 0);
            check($sformatf("vec%0d col", i), int'(cursor_col), vecs[i].col);
            check($sformatf("vec%0d row", i), int'(cursor_row), vecs[i].row);
            check($sformatf("vec%0d ready", i), int'(char_ready), 1);
        end

        // Full row of printables, then wrap into a clear of row 1.
        badw = 0;
        for (int i = 0; i < 80; i++) begin
            send(8'h41 + 8'(i % 26));
            if (!wr_en || int'(wr_addr) != i || int'(wr_data) != 8'h21 + (i % 26)) badw++;
        end
        check("row fill writes", badw, 0);
        tick();
        count_clear(80, 80, "wrap row clear");
        check("wrap col", int'(cursor_col), 0);
        check("wrap row", int'(cursor_row), 1);

        // BS at (2,10) and at (2,0).
        send(8'h0A);
        count_clear(160, 80, "lf row2 clear");
        for (int i = 0; i < 10; i++) send(8'h78);
        tick();
        check("pre-bs col", int'(cursor_col), 10);
        send(8'h08);
        check("bs wr_en", int'(wr_en), 1);
        check("bs addr", int'(wr_addr), 169);
        check("bs data", int'(wr_data), 0);
        tick();
        check("bs col", int'(cursor_col), 9);
        check("bs row", int'(cursor_row), 2);
        send(8'h0D);
        send(8'h08);
        check("bs0 wr_en", int'(wr_en), 0);
        check("bs0 col", int'(cursor_col), 0);
        check("bs0 row", int'(cursor_row), 2);
        check("bs0 ready", int'(char_ready), 1);

        // LF at row 39 wraps to row 0.
        for (int i = 0; i < 37; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h30);
        check("row39 last addr", int'(wr_addr), 3124);
        tick();
        check("row39 col", int'(cursor_col), 5);
        check("row39 row", int'(cursor_row), 39);
        send(8'h0A);
        check("lf wrap col", int'(cursor_col), 0);
        check("lf wrap row", int'(cursor_row), 0);
        count_clear(0, 80, "lf wrap clear");

        // FF with the next byte held on the bus.
        send(8'h51);
        tick();
        check("pre-ff col", int'(cursor_col), 1);
        char_in    = 8'h0C;
        char_valid = 1'b1;
        tick();
        char_in = 8'h41;
        check("ff col", int'(cursor_col), 0);
        check("ff row", int'(cursor_row), 0);
        count_clear(0, 3200, "ff clear");
        tick();
        char_valid = 1'b0;
        check("held wr_en", int'(wr_en), 1);
        check("held addr", int'(wr_addr), 0);
        check("held data", int'(wr_data), 8'h21);
        tick();
        check("held col", int'(cursor_col), 1);

        // Reset in the middle of a clear restarts it from cell 0.
        send(8'h0C);
        repeat (100) tick();
        check("mid-clear addr", int'(wr_addr), 100);
        reset_n = 1'b0;
        tick();
        check("mid reset wr_en", int'(wr_en), 0);
        check("mid reset addr", int'(wr_addr), 0);
        check("mid reset ready", int'(char_ready), 0);
        tick();
        reset_n = 1'b1;
        count_clear(0, 3200, "restart clear");
        check("restart col", int'(cursor_col), 0);
        check("restart row", int'(cursor_row), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
